alu_seq_ctrl: RTL and testbench

//   Command sequencer wrapped around the combinational ALU. Accepts one operation
//   per valid/ready handshake, drives the ALU's sel/A/B from registers, and captures C/Z.
//   It returns a registered result with zero/overflow/error flags over a valid/ready port.
//   An accumulator register lets chained operations reuse the previous result as operand A.

---
 rtl/alu_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Command sequencer wrapped around an external combinational ALU. One
//   operation is accepted per valid/ready handshake; the operands and op code
//   are registered and drive the ALU, whose result is captured one cycle later
//   together with zero/overflow/error flags and returned over a valid/ready
//   response port. An accumulator holds the last error-free result so chained
//   operations can use it as operand A.
//
//   State | Meaning
//   IDLE  | waiting for a command (o_cmd_ready = 1)
//   ISSUE | operands on the ALU, result captured at the next edge
//   HOLD  | response presented until the consumer takes it
//
// Ports
//   i_clk, i_rst                 clock, async active-high reset
//   i_cmd_valid / o_cmd_ready    command handshake
//   i_cmd_op, i_cmd_acc          op code, use accumulator as operand A
//   i_cmd_a, i_cmd_b             signed operands
//   o_alu_sel, o_alu_a, o_alu_b  registered drive to the ALU
//   i_alu_c, i_alu_z             ALU result and zero flag
//   o_rsp_valid / i_rsp_ready    response handshake
//   o_rsp_data                   signed result
//   o_rsp_zero, o_rsp_ovf,
//   o_rsp_err                    zero, signed overflow, divide/mod by zero
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic             i_cmd_acc,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    output logic [2:0]       o_alu_sel,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic [WIDTH-1:0] i_alu_c,
    input  logic             i_alu_z,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_zero,
    output logic             o_rsp_ovf,
    output logic             o_rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

    state_t           r_state;
    logic [2:0]       r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_ovf;
    logic             r_rsp_err;

    logic             w_sa;
    logic             w_sb;
    logic             w_sc;
    logic             w_err;
    logic             w_ovf;

    assign w_sa = r_a[WIDTH-1];
    assign w_sb = r_b[WIDTH-1];
    assign w_sc = i_alu_c[WIDTH-1];

    // Divide and mod by zero: the ALU output is meaningless, so it is ignored.
    assign w_err = ((r_sel == OP_DIV) || (r_sel == OP_MOD)) && (r_b == '0);

    always_comb begin
        w_ovf = 1'b0;
        case (r_sel)
            OP_ADD:  w_ovf = (w_sa == w_sb) && (w_sc != w_sa);
            OP_SUB:  w_ovf = (w_sa != w_sb) && (w_sc != w_sa);
            // Only quotient that does not fit: MOST_NEG / -1
            OP_DIV:  w_ovf = (r_a == MOST_NEG) && (r_b == MINUS_ONE);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_sel   <= i_cmd_op;
                        r_b     <= i_cmd_b;
                        r_a     <= i_cmd_acc ? r_acc : i_cmd_a;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_err) begin
                        r_rsp_data <= '0;
                        r_rsp_zero <= 1'b0;
                        r_rsp_ovf  <= 1'b0;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_rsp_data <= i_alu_c;
                        r_rsp_zero <= i_alu_z;
                        r_rsp_ovf  <= w_ovf;
                        r_rsp_err  <= 1'b0;
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (!r_rsp_err) begin
                            r_acc <= r_rsp_data;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready = (r_state == IDLE);
    assign o_alu_sel   = r_sel;
    assign o_alu_a     = r_a;
    assign o_alu_b     = r_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_zero  = r_rsp_zero;
    assign o_rsp_ovf   = r_rsp_ovf;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Directed bench for alu_seq_ctrl (WIDTH=16) with a behavioural ALU model
//   connected to the sequencer's ALU ports.
module tb_alu_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_acc;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_c;
    logic             alu_z;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_ovf;
    logic             rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl #(.WIDTH(WIDTH)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_acc   (cmd_acc),
        .i_cmd_a     (cmd_a),
        .i_cmd_b     (cmd_b),
        .o_alu_sel   (alu_sel),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .i_alu_c     (alu_c),
        .i_alu_z     (alu_z),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_zero  (rsp_zero),
        .o_rsp_ovf   (rsp_ovf),
        .o_rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU: computed at 32 bits, truncated to WIDTH.
    int          ia;
    int          ib;
    logic [31:0] ir;
    always_comb begin
        ia = int'($signed(alu_a));
        ib = int'($signed(alu_b));
        ir = '0;
        case (alu_sel)
            3'b000:  ir = ia + ib;
            3'b001:  ir = ia - ib;
            3'b010:  ir = ia * ib;
            3'b011:  ir = (ib != 0) ? ia / ib : 0;
            3'b100:  ir = (ib != 0) ? ia % ib : 0;
            default: ir = ia;
        endcase
        alu_c = ir[WIDTH-1:0];
        alu_z = (ir[WIDTH-1:0] == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full transaction starting 1ns after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic acc,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_d, input logic ez,
                          input logic eo, input logic ee);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_acc   = acc;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a     = 16'hBEEF;
        cmd_b     = 16'hBEEF;
        check({tag, "_lat1"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        check({tag, "_flags"}, {29'd0, rsp_zero, rsp_ovf, rsp_err}, {29'd0, ez, eo, ee});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_acc   = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu", {13'd0, alu_sel, alu_a}, 32'd0);
        check("rst_rsp", {13'd0, rsp_zero, rsp_ovf, rsp_err, rsp_data}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add",      3'b000, 1'b0, 16'd100,  16'd23,   16'd123,  1'b0, 1'b0, 1'b0);
        run_op("sub_zero", 3'b001, 1'b0, 16'd5,    16'd5,    16'd0,    1'b1, 1'b0, 1'b0);
        run_op("div0",     3'b011, 1'b0, 16'd7,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1);
        // acc must still be 0 after the error
        run_op("acc_add",  3'b000, 1'b1, 16'd999,  16'd1,    16'd1,    1'b0, 1'b0, 1'b0);
        run_op("mod0",     3'b100, 1'b0, 16'd9,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1);
        run_op("add_ovf",  3'b000, 1'b0, 16'h7FFF, 16'd1,    16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf",  3'b001, 1'b0, 16'h8000, 16'd1,    16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg",  3'b001, 1'b0, 16'd3,    16'd10,   16'hFFF9, 1'b0, 1'b0, 1'b0);
        run_op("div_ovf",  3'b011, 1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("div_neg",  3'b011, 1'b0, 16'hFFF9, 16'd2,    16'hFFFD, 1'b0, 1'b0, 1'b0);
        run_op("mul_trn",  3'b010, 1'b0, 16'h4000, 16'd4,    16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("pass",     3'b111, 1'b0, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0, 1'b0);

        run_op("ch_add",   3'b000, 1'b0, 16'd10,   16'd5,    16'd15,   1'b0, 1'b0, 1'b0);
        run_op("ch_mul",   3'b010, 1'b1, 16'd999,  16'd3,    16'd45,   1'b0, 1'b0, 1'b0);
        run_op("ch_mod",   3'b100, 1'b1, 16'd777,  16'd7,    16'd3,    1'b0, 1'b0, 1'b0);

        // Stall: response held for 5 clocks while a new command waits.
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_acc = 1'b0; cmd_a = 16'd1; cmd_b = 16'd2;
        @(posedge clk); #1;
        cmd_a = 16'd40; cmd_b = 16'd50;
        @(posedge clk); #1;
        check("stall_valid0", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {12'd0, rsp_valid, rsp_zero, rsp_ovf, rsp_err, rsp_data},
                  {12'd0, 4'b1000, 16'd3});
            check("stall_ready", 32'(cmd_ready), 32'd0);
            check("stall_opnd", 32'(alu_a), 32'd1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_done", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("stall_idle", {30'd0, cmd_ready, rsp_valid}, {30'd0, 2'b10});

        // Reset while holding a response.
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_acc = 1'b0; cmd_a = 16'd20; cmd_b = 16'd22;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rh_valid", 32'(rsp_valid), 32'd1);
        check("rh_data", 32'(rsp_data), 32'd42);
        #2 rst = 1'b1;
        #1;
        check("rh_async", {30'd0, rsp_valid, cmd_ready}, {30'd0, 2'b01});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("post_rst", 3'b000, 1'b1, 16'd500, 16'd7, 16'd7, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
